// File: rtl/whack_a_mole_core_n.sv
// whack_a_mole_core_n: N-mole game core (clk, rst, ena, start, btn in; mole, score, misses, round_cnt, hit_pulse, miss_pulse, game_end, busy out)
module whack_a_mole_core_n #(
  parameter int N_MOLES = 8,
  parameter int SCORE_W = 8,
  parameter int ROUNDS = 16,
  parameter int WINDOW_INIT = 50000,
  parameter int WINDOW_STEP = 2000,
  parameter int WINDOW_MIN = 10000,
  parameter int GAP_CYCLES = 20000,
  parameter int PENALTY = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int IDX_W = $clog2(N_MOLES),
  localparam int ROUND_W = $clog2(ROUNDS + 1),
  localparam int TIMER_W = $clog2(WINDOW_INIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic [N_MOLES-1:0] btn,
  output logic [N_MOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_end,
  output logic               busy
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] G_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] W_INIT = TIMER_W'(WINDOW_INIT);
  localparam logic [TIMER_W-1:0] W_STEP = TIMER_W'(WINDOW_STEP);
  localparam logic [TIMER_W-1:0] W_MIN = TIMER_W'(WINDOW_MIN);
  localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
  localparam logic [ROUND_W-1:0] R_LAST = ROUND_W'(ROUNDS - 1);
  typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;
  state_t state;
  logic [N_MOLES-1:0] s1, s2, prev, press;
  logic [15:0] lfsr;
  logic [TIMER_W-1:0] window, timer;
  logic [GAP_W-1:0] gcnt;
  logic [IDX_W-1:0] last_idx, c0, c1, cand;
  logic hit, wrong;
  always_comb begin
    press = s2 & ~prev;
    hit = |(press & mole);
    wrong = |(press & ~mole);
    c0 = lfsr[IDX_W-1:0];
    c1 = int'(c0) >= N_MOLES ? c0 - IDX_W'(N_MOLES) : c0;
    cand = c1 != last_idx ? c1 : (int'(c1) == N_MOLES - 1 ? '0 : c1 + 1'b1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      lfsr <= LFSR_SEED;
      window <= W_INIT;
      timer <= '0;
      gcnt <= '0;
      last_idx <= '0;
      mole <= '0;
      score <= '0;
      misses <= '0;
      round_cnt <= '0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      game_end <= 1'b0;
      busy <= 1'b0;
    end else if (!ena) begin
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      prev <= s2;
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          score <= '0;
          misses <= '0;
          round_cnt <= '0;
          window <= W_INIT;
          gcnt <= G_LAST;
          state <= GAP;
          busy <= 1'b1;
          game_end <= 1'b0;
        end
        GAP: if (gcnt == '0) begin
          state <= UP;
          mole <= {{(N_MOLES-1){1'b0}}, 1'b1} << cand;
          last_idx <= cand;
          timer <= window;
        end else gcnt <= gcnt - 1'b1;
        UP: if (hit || timer == T_ONE) begin
          mole <= '0;
          round_cnt <= round_cnt + 1'b1;
          if (hit) begin
            score <= score == '1 ? score : score + 1'b1;
            hit_pulse <= 1'b1;
            window <= int'(window) >= WINDOW_MIN + WINDOW_STEP ? window - W_STEP : W_MIN;
          end else begin
            misses <= misses == '1 ? misses : misses + 1'b1;
            miss_pulse <= 1'b1;
          end
          if (round_cnt == R_LAST) begin
            state <= DONE;
            busy <= 1'b0;
            game_end <= 1'b1;
          end else begin
            state <= GAP;
            gcnt <= G_LAST;
          end
        end else begin
          timer <= timer - 1'b1;
          if (PENALTY != 0 && wrong) begin
            score <= score == '0 ? score : score - 1'b1;
            miss_pulse <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
